// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF race controller.
package ro_puf_pkg;

    localparam int TIMER_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        RACE,
        RECORD,
        DONE
    } state_e;

    // Bit offset of RO pair idx inside the packed challenge word.
    function automatic int unsigned pair_off(
        input int unsigned idx,
        input int unsigned sel_w
    );
        return idx * 2 * sel_w;
    endfunction

endpackage

// File: rtl/race_timer.sv
// Loadable up-counter with a terminal-count compare, shared by SETTLE and RACE.
module race_timer
    import ro_puf_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               en_i,
    input  logic [TIMER_W-1:0] cmp_i,
    output logic               tc_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == cmp_i);

endmodule

// File: rtl/ro_race_controller.sv
// Sequences one RO-pair race per response bit and records the winner.
module ro_race_controller
    import ro_puf_pkg::*;
#(
    parameter int RESP_BITS  = 8,
    parameter int SEL_W      = 4,
    parameter int SETTLE_CYC = 4,
    parameter int TIMEOUT    = 4095
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [RESP_BITS*2*SEL_W-1:0] challenge,
    input  logic                         fin_a,
    input  logic                         fin_b,
    output logic [SEL_W-1:0]             sel_a,
    output logic [SEL_W-1:0]             sel_b,
    output logic                         cnt_clear,
    output logic                         cnt_enable,
    output logic                         busy,
    output logic                         done,
    output logic [RESP_BITS-1:0]         response,
    output logic                         response_valid,
    output logic [RESP_BITS-1:0]         tie_flags,
    output logic [RESP_BITS-1:0]         timeout_flags
);

    localparam int CH_W  = RESP_BITS * 2 * SEL_W;
    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(RESP_BITS - 1);
    localparam logic [TIMER_W-1:0] SETTLE_TC = TIMER_W'(SETTLE_CYC - 1);
    localparam logic [TIMER_W-1:0] RACE_TC   = TIMER_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [CH_W-1:0]      chal_q, chal_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SEL_W-1:0]     sel_a_q, sel_a_d;
    logic [SEL_W-1:0]     sel_b_q, sel_b_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic [RESP_BITS-1:0] tie_q, tie_d;
    logic [RESP_BITS-1:0] tmo_q, tmo_d;
    logic                 rv_q, rv_d;
    logic                 bit_q, bit_d;

    logic                 t_load;
    logic                 t_en;
    logic [TIMER_W-1:0]   t_cmp;
    logic                 t_tc;

    race_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (t_load),
        .en_i   (t_en),
        .cmp_i  (t_cmp),
        .tc_o   (t_tc)
    );

    always_comb begin
        state_d = state_q;
        chal_d  = chal_q;
        idx_d   = idx_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        resp_d  = resp_q;
        tie_d   = tie_q;
        tmo_d   = tmo_q;
        rv_d    = rv_q;
        bit_d   = bit_q;
        t_load  = 1'b0;
        t_en    = 1'b0;
        t_cmp   = (state_q == RACE) ? RACE_TC : SETTLE_TC;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    idx_d   = '0;
                    resp_d  = '0;
                    tie_d   = '0;
                    tmo_d   = '0;
                    rv_d    = 1'b0;
                    sel_a_d = challenge[SEL_W-1:0];
                    sel_b_d = challenge[2*SEL_W-1:SEL_W];
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                t_load  = 1'b1;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (t_tc) begin
                    t_load  = 1'b1;
                    state_d = RACE;
                end else begin
                    t_en = 1'b1;
                end
            end
            RACE: begin
                t_en = 1'b1;
                // A finish seen on the timeout cycle still wins over the timeout.
                if (fin_a || fin_b || t_tc) begin
                    bit_d   = fin_a & ~fin_b;
                    state_d = RECORD;
                    if (fin_a && fin_b) begin
                        tie_d[idx_q] = 1'b1;
                    end else if (!fin_a && !fin_b) begin
                        tmo_d[idx_q] = 1'b1;
                    end
                end
            end
            RECORD: begin
                resp_d[idx_q] = bit_q;
                if (idx_q == LAST_IDX) begin
                    rv_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    sel_a_d = chal_q[pair_off(int'(idx_q) + 1, SEL_W) +: SEL_W];
                    sel_b_d = chal_q[pair_off(int'(idx_q) + 1, SEL_W) + SEL_W +: SEL_W];
                    state_d = CLEAR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            rv_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            chal_q  <= '0;
            idx_q   <= '0;
            sel_a_q <= '0;
            sel_b_q <= '0;
            resp_q  <= '0;
            tie_q   <= '0;
            tmo_q   <= '0;
            rv_q    <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chal_q  <= chal_d;
            idx_q   <= idx_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            resp_q  <= resp_d;
            tie_q   <= tie_d;
            tmo_q   <= tmo_d;
            rv_q    <= rv_d;
            bit_q   <= bit_d;
        end
    end

    assign sel_a          = sel_a_q;
    assign sel_b          = sel_b_q;
    assign cnt_clear      = (state_q == CLEAR);
    assign cnt_enable     = (state_q == RACE);
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign response       = resp_q;
    assign response_valid = rv_q;
    assign tie_flags      = tie_q;
    assign timeout_flags  = tmo_q;

endmodule

// File: tb/tb_ro_race_controller.sv
// Self-checking bench: table vectors, randomized races vs a race-outcome model.
module tb_ro_race_controller;

    localparam int NB = 8;
    localparam int SW = 4;
    localparam int SC = 4;
    localparam int TO = 100;
    localparam int NEVER = 100000;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [63:0]     challenge = '0;
    logic            fin_a = 1'b0;
    logic            fin_b = 1'b0;
    logic [SW-1:0]   sel_a, sel_b;
    logic            cnt_clear, cnt_enable, busy, done, response_valid;
    logic [NB-1:0]   response, tie_flags, timeout_flags;
    logic [36:0]     outs;

    ro_race_controller #(
        .RESP_BITS (NB),
        .SEL_W     (SW),
        .SETTLE_CYC(SC),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .challenge     (challenge),
        .fin_a         (fin_a),
        .fin_b         (fin_b),
        .sel_a         (sel_a),
        .sel_b         (sel_b),
        .cnt_clear     (cnt_clear),
        .cnt_enable    (cnt_enable),
        .busy          (busy),
        .done          (done),
        .response      (response),
        .response_valid(response_valid),
        .tie_flags     (tie_flags),
        .timeout_flags (timeout_flags)
    );

    always #5 clk = ~clk;

    assign outs = {sel_a, sel_b, cnt_clear, cnt_enable, busy, done,
                   response, response_valid, tie_flags, timeout_flags};

    typedef struct {
        logic [7:0][7:0] da;
        logic [7:0][7:0] db;
        logic [7:0]      resp;
        logic [7:0]      tie;
        logic [7:0]      tmo;
        bit              inj;
    } vec_t;

    vec_t        vecs[6];
    int          da_t[NB];
    int          db_t[NB];
    logic [63:0] chal_cur;
    logic [63:0] plan_chal;
    int nclr, cur_bit, race_cyc, busy_cyc, done_cnt, sel_err;
    int checks = 0;
    int failures = 0;

    // Bench-side counters: a finishes after da enabled cycles (0 = never).
    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (cnt_clear) begin
            cur_bit  = nclr;
            nclr++;
            race_cyc = 0;
            if (cur_bit < NB) begin
                if (sel_a !== chal_cur[cur_bit*8 +: 4] ||
                    sel_b !== chal_cur[cur_bit*8+4 +: 4]) sel_err++;
            end
        end
        if (cnt_enable) race_cyc++;
        if (cur_bit < NB) begin
            fin_a = race_cyc > 0 && da_t[cur_bit] != 0 && race_cyc >= da_t[cur_bit];
            fin_b = race_cyc > 0 && db_t[cur_bit] != 0 && race_cyc >= db_t[cur_bit];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_delays(input logic [7:0][7:0] da, input logic [7:0][7:0] db);
        for (int i = 0; i < NB; i++) begin
            da_t[i] = int'(da[i]);
            db_t[i] = int'(db[i]);
        end
    endtask

    task automatic model(output logic [7:0] r, output logic [7:0] t,
                         output logic [7:0] o, output int cyc);
        r = '0; t = '0; o = '0; cyc = 1;
        for (int i = 0; i < NB; i++) begin
            int a, b, m, rc;
            a = (da_t[i] == 0) ? NEVER : da_t[i];
            b = (db_t[i] == 0) ? NEVER : db_t[i];
            m = (a < b) ? a : b;
            if (m > TO) begin
                o[i] = 1'b1;
                rc = TO;
            end else begin
                rc = m;
                if (a == b) t[i] = 1'b1;
                else if (a < b) r[i] = 1'b1;
            end
            cyc += 2 + SC + rc;
        end
    endtask

    task automatic clear_mon(input logic [63:0] chal);
        chal_cur = chal;
        nclr = 0; cur_bit = 0; race_cyc = 0;
        busy_cyc = 0; done_cnt = 0; sel_err = 0;
    endtask

    task automatic run_check(input string nm, input logic [63:0] chal, input bit inj,
                             input logic [7:0] er, input logic [7:0] et,
                             input logic [7:0] eo, input int ecyc);
        int k;
        @(posedge clk); #1;
        clear_mon(chal);
        start = 1'b1;
        challenge = chal;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(done_cnt > 0 && !busy) && k < 3000) begin
            @(posedge clk); #1;
            start = inj && (k == 10);
            if (inj && k == 10) challenge = ~chal;
            k++;
        end
        start = 1'b0;
        chk({nm, " resp"}, response, er);
        chk({nm, " tie"}, tie_flags, et);
        chk({nm, " tmo"}, timeout_flags, eo);
        chk({nm, " rvalid"}, response_valid, 1);
        chk({nm, " done_cnt"}, done_cnt, 1);
        chk({nm, " busy_cyc"}, busy_cyc, ecyc);
        chk({nm, " clears"}, nclr, NB);
        chk({nm, " sel_err"}, sel_err, 0);
        repeat (2) @(posedge clk);
        #1;
        chk({nm, " hold"}, {response_valid, response, busy}, {1'b1, er, 1'b0});
        challenge = chal;
    endtask

    initial begin
        logic [7:0] r, t, o;
        int cyc, k;
        logic [63:0] c;

        for (int i = 0; i < NB; i++) begin
            plan_chal[i*8 +: 4]   = 4'(2 * i + 1);
            plan_chal[i*8+4 +: 4] = 4'(2 * i + 2);
        end
        vecs[0] = '{da: {8{8'd3}}, db: {8{8'd6}},
                    resp: 8'hFF, tie: 8'h00, tmo: 8'h00, inj: 1'b0};
        vecs[1] = '{da: {4{8'd4, 8'd2}}, db: {4{8'd2, 8'd4}},
                    resp: 8'h55, tie: 8'h00, tmo: 8'h00, inj: 1'b0};
        vecs[2] = '{da: {8'd2, 8'd2, 8'd2, 8'd2, 8'd5, 8'd2, 8'd2, 8'd2},
                    db: {8'd3, 8'd3, 8'd3, 8'd3, 8'd5, 8'd3, 8'd3, 8'd3},
                    resp: 8'hF7, tie: 8'h08, tmo: 8'h00, inj: 1'b0};
        vecs[3] = '{da: {8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1},
                    db: {8'd2, 8'd2, 8'd0, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2},
                    resp: 8'hDF, tie: 8'h00, tmo: 8'h20, inj: 1'b0};
        vecs[4] = '{da: {8{8'd1}}, db: {8{8'd1}},
                    resp: 8'h00, tie: 8'hFF, tmo: 8'h00, inj: 1'b1};
        vecs[5] = '{da: {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd101, 8'd0},
                    db: {8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd0, 8'd100},
                    resp: 8'hFC, tie: 8'h00, tmo: 8'h02, inj: 1'b0};

        load_delays('0, '0);
        clear_mon('0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset outs", {27'd0, outs}, 64'd0);
        reset = 1'b1;

        for (int v = 0; v < 6; v++) begin
            load_delays(vecs[v].da, vecs[v].db);
            model(r, t, o, cyc);
            run_check($sformatf("vec%0d", v), plan_chal, vecs[v].inj,
                      vecs[v].resp, vecs[v].tie, vecs[v].tmo, cyc);
        end

        for (int n = 0; n < 12; n++) begin
            c = {$urandom, $urandom};
            for (int i = 0; i < NB; i++) begin
                da_t[i] = int'($urandom_range(0, 110));
                db_t[i] = int'($urandom_range(0, 110));
                if ($urandom_range(0, 5) == 0) db_t[i] = da_t[i];
            end
            model(r, t, o, cyc);
            run_check($sformatf("rnd%0d", n), c, 1'b0, r, t, o, cyc);
        end

        // Abort while bit 2 is racing with no finisher.
        load_delays({8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1},
                    {8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd0, 8'd2, 8'd2});
        @(posedge clk); #1;
        clear_mon(plan_chal);
        start = 1'b1;
        challenge = plan_chal;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(cnt_enable && nclr == 3) && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("abort reach race", {cnt_enable, 8'(nclr)}, {1'b1, 8'd3});
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort enable", cnt_enable, 0);
        chk("abort rvalid", response_valid, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort no done", done_cnt, 0);
        chk("abort partial", response[1:0], 2'b11);
        load_delays(vecs[1].da, vecs[1].db);
        model(r, t, o, cyc);
        run_check("post abort", plan_chal, 1'b0, 8'h55, 8'h00, 8'h00, cyc);

        // Reset pulse during SETTLE of bit 0.
        load_delays(vecs[0].da, vecs[0].db);
        @(posedge clk); #1;
        clear_mon(plan_chal);
        start = 1'b1;
        challenge = plan_chal;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(nclr == 1 && busy && !cnt_clear) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst reach settle", {cnt_enable, 8'(nclr)}, {1'b0, 8'd1});
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("rst mid outs", {27'd0, outs}, 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("rst stays idle", {busy, 8'(done_cnt)}, 9'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
